toggle_event_decoder: RTL
=========================

TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on tog_in (legal 2..4).
REQ-002 Parameter CNT_W, default 8, width of the event counter.
REQ-003 Parameter PEND_MAX, default 15, capacity of the pending-event buffer (legal 1..15).
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tog_in  input  1  level from a toggle transmitter; each transition is one event; asynchronous to Clock.
REQ-007 phase_load  input  1  realigns the reference level to the current synchronized tog_in without producing an event.
REQ-008 ev_ready  input  1  consumer accepts one pending event.
REQ-009 clear_ovf  input  1  clears the sticky overflow flag.
REQ-010 ev_valid  output  1  at least one event pending.
REQ-011 ev_pulse  output  1  one-cycle strobe per detected transition.
REQ-012 ev_count  output  CNT_W  running count of detected transitions.
REQ-013 pend  output  4  number of pending events.
REQ-014 overflow  output  1  sticky; an event was dropped because the buffer was full.

Function
REQ-015 tog_in SHALL pass through SYNC_STAGES flops; only the last stage (sync_q) feeds the logic.
REQ-016 A register ref_q SHALL hold the last accepted level; detect = (sync_q != ref_q) and not phase_load.
REQ-017 ref_q SHALL load sync_q every cycle, including phase_load cycles.
REQ-018 ev_pulse SHALL be registered: high for exactly one cycle, starting SYNC_STAGES+1 rising edges after the first edge that samples the new tog_in level.
REQ-019 Back-to-back transitions one sync'd cycle apart SHALL produce back-to-back ev_pulse cycles, with no merging.
REQ-020 ev_count SHALL increment by 1 on every detect, including dropped events, and wrap modulo 2^CNT_W with no flag.
REQ-021 Pop SHALL be defined as ev_valid and ev_ready; ev_valid SHALL equal (pend != 0).
REQ-022 pend update: detect only -> +1; pop only -> -1; detect and pop -> unchanged; neither -> unchanged.
REQ-023 Detect with pend == PEND_MAX and no pop SHALL leave pend at PEND_MAX and set overflow.
REQ-024 Detect with pend == PEND_MAX and a simultaneous pop SHALL leave pend at PEND_MAX and SHALL NOT set overflow.
REQ-025 ev_ready while pend == 0 SHALL be ignored: no underflow.
REQ-026 clear_ovf SHALL clear overflow next cycle; if a set condition occurs in the same cycle, set SHALL win.
REQ-027 phase_load SHALL NOT alter pend, ev_count or overflow, for use after the transmitter is preset to 1.

Reset
REQ-028 On reset, all sync flops, ref_q, ev_pulse, ev_count, pend and overflow SHALL be 0, and ev_valid SHALL be 0 in the following cycle.
REQ-029 reset SHALL take priority over all inputs, and a transition in flight during reset SHALL be discarded.
REQ-030 After reset the reference level SHALL be 0, matching a transmitter cleared by the same reset; a tog_in held at 1 through reset SHALL yield one event after release unless phase_load is asserted.

Structure
REQ-031 Package toggle_pkg SHALL hold the default SYNC_STAGES, CNT_W and PEND_MAX constants and the pend width constant (4).
REQ-032 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports Clock, reset, d, q), reusable elsewhere.
REQ-033 Total RTL SHALL be one top module plus sync_chain, with no latches and no combinational path from tog_in to any output.

Verification
REQ-034 reset, then tog_in 0->1 -> ev_pulse high for one cycle exactly 3 edges later; ev_count=1; pend=1; ev_valid=1.
REQ-035 Five transitions every 4 cycles with ev_ready=0 -> pend=5, ev_count=5, overflow=0; then ev_ready=1 for 5 cycles -> pend=0, ev_valid=0.
REQ-036 16 transitions with ev_ready=0 -> pend=15, overflow=1, ev_count=16; clear_ovf pulse -> overflow=0, pend stays 15.
REQ-037 pend=15, a transition arrives together with ev_ready=1 -> pend=15, overflow=0; a transition arrives while pend=0 with ev_ready=1 -> pend=1.
REQ-038 tog_in=1 through reset, then phase_load for 1 cycle after the synchronizer fills -> no ev_pulse, ev_count=0; a later 1->0 transition -> ev_count=1.
REQ-039 ev_count preloaded by 255 transitions with CNT_W=8, then one more -> ev_count wraps to 0; reset asserted mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/toggle_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toggle_pkg
// Purpose  : Shared defaults and widths for the toggle event decoder.
// Revision : 1.0 - initial release
// ============================================================================
package toggle_pkg;

  localparam int SYNC_STAGES_DEF = 2;   // synchronizer depth on tog_in
  localparam int CNT_W_DEF       = 8;   // event counter width
  localparam int PEND_MAX_DEF    = 15;  // pending-event buffer capacity
  localparam int PEND_W          = 4;   // width of the pending count

endpackage : toggle_pkg
`default_nettype wire

// File: rtl/toggle_event_decoder_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Purpose  : Multi-flop synchronizer for a single-bit asynchronous level.
//            Reset clears every stage so that nothing captured before or
//            during reset can leak out after release.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic Clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;

  // Shift the asynchronous level through the chain; stage 0 is the capture flop.
  always_ff @(posedge Clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : toggle_event_decoder
// Purpose  : Turns each transition of an asynchronous toggle level into a
//            one-cycle event strobe, keeps a running event count and a
//            bounded count of events waiting for a consumer, and flags
//            (sticky) any event dropped because that count was saturated.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_event_decoder
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PEND_MAX    = PEND_MAX_DEF
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              tog_in,
  input  logic              phase_load,
  input  logic              ev_ready,
  input  logic              clear_ovf,
  output logic              ev_valid,
  output logic              ev_pulse,
  output logic [CNT_W-1:0]  ev_count,
  output logic [PEND_W-1:0] pend,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

  logic              sync_q;
  logic              ref_q;
  logic              detect;
  logic              pop;
  logic              ovf_set;
  logic [PEND_W-1:0] pend_next;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .Clock (Clock),
    .reset (reset),
    .d     (tog_in),
    .q     (sync_q)
  );

  // A transition is a difference from the last accepted level, unless the
  // caller is realigning the reference this cycle.
  always_comb begin
    detect = (sync_q != ref_q) && !phase_load;
  end

  assign ev_valid = (pend != '0);
  assign pop      = ev_valid && ev_ready;

  // Next pending count: a simultaneous detect and pop cancel out, and a
  // detect against a saturated buffer with no pop is the only drop case.
  always_comb begin
    pend_next = pend;
    ovf_set   = 1'b0;
    case ({detect, pop})
      2'b10: begin
        if (pend == PEND_FULL) begin
          ovf_set = 1'b1;
        end else begin
          pend_next = pend + PEND_W'(1);
        end
      end
      2'b01:   pend_next = pend - PEND_W'(1);
      default: pend_next = pend;
    endcase
  end

  // Reference level tracks the synchronized input every cycle.
  always_ff @(posedge Clock) begin
    if (reset) begin
      ref_q <= 1'b0;
    end else begin
      ref_q <= sync_q;
    end
  end

  // Registered strobe and wrapping counter; dropped events are still counted.
  always_ff @(posedge Clock) begin
    if (reset) begin
      ev_pulse <= 1'b0;
      ev_count <= '0;
    end else begin
      ev_pulse <= detect;
      if (detect) begin
        ev_count <= ev_count + CNT_W'(1);
      end
    end
  end

  // Pending count register.
  always_ff @(posedge Clock) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  // Sticky overflow; a new drop outranks a clear in the same cycle.
  always_ff @(posedge Clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule : toggle_event_decoder
`default_nettype wire
